switch_arbiter: RTL and testbench

Central scheduler for the 4-port switch. It collects per-port forwarding requests and grants each port permission to pop its FIFO head. It also drives the per-output 4:1 mux selects for the transmit cycle. It resolves output contention, including multicast destination masks, with rotating round-robin priority plus a starvation override, and honours per-output backpressure.

---
 rtl/switch_arbiter_pkg.sv | 15 +
 rtl/switch_arbiter_rr_pick.sv | 45 ++++
 rtl/switch_arbiter.sv | 142 ++++++++++++++
 tb/tb_switch_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_arbiter_pkg.sv
// Shared types for the 4-port switch scheduler: port masks, port indices and
// the rotating-order helper used by the grant scan.
package switch_arbiter_pkg;

    localparam int NUM_PORTS = 4;

    typedef logic [3:0] port_mask_t;
    typedef logic [1:0] port_idx_t;

    // k-th port in rotating order starting at base (wraps mod 4).
    function automatic port_idx_t rot_idx(input port_idx_t base, input int k);
        return base + port_idx_t'(k);
    endfunction

endpackage

// File: rtl/switch_arbiter_rr_pick.sv
// Combinational rotating-priority grant scan: starving ports first, then the
// rest, each pass starting at rr_ptr; a port wins only if its dst is unclaimed.
module rr_pick
    import switch_arbiter_pkg::*;
(
    input  port_mask_t  eligible,
    input  port_mask_t  starving,
    input  logic [15:0] dst,
    input  port_idx_t   rr_ptr,
    output port_mask_t  grant,
    output port_idx_t   first_idx,
    output logic        any_grant
);

    port_mask_t claimed;
    port_mask_t cand;
    port_mask_t d;
    port_idx_t  idx;

    always_comb begin
        grant     = '0;
        first_idx = '0;
        any_grant = 1'b0;
        claimed   = '0;
        cand      = '0;
        d         = '0;
        idx       = '0;
        for (int pass = 0; pass < 2; pass++) begin
            cand = (pass == 0) ? (eligible & starving) : (eligible & ~starving);
            for (int k = 0; k < 4; k++) begin
                idx = rot_idx(rr_ptr, k);
                d   = dst[4*idx +: 4];
                if (cand[idx] && ((d & claimed) == '0)) begin
                    grant[idx] = 1'b1;
                    claimed    = claimed | d;
                    if (!any_grant) begin
                        first_idx = idx;
                        any_grant = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/switch_arbiter.sv
// Central scheduler for the 4-port switch: grants FIFO pops and drives the
// per-output mux selects one cycle later. Optional macro ARB_STATS_EN adds
// per-port 16-bit grant counters on grant_cnt.
module switch_arbiter
    import switch_arbiter_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int STARVE_LIMIT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] req_dst,
    input  logic [3:0]  out_ready,
    output logic [3:0]  grant,
    output logic [3:0]  out_valid,
    output logic [7:0]  out_sel
`ifdef ARB_STATS_EN
    ,
    output logic [63:0] grant_cnt
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    port_mask_t grant_q, grant_d;
    port_mask_t sel_valid_q, sel_valid_d;
    port_mask_t out_valid_q, out_valid_d;
    port_idx_t  rr_ptr_q, rr_ptr_d;
    logic [7:0] sel_idx_q, sel_idx_d;
    logic [7:0] out_sel_q, out_sel_d;
    logic [3:0] wait_cnt_q [NUM_PORTS];
    logic [3:0] wait_cnt_d [NUM_PORTS];

    port_mask_t eligible, starving, pick_grant, dst_i;
    port_idx_t  first_idx;
    logic       any_grant;

    // A port whose grant is showing this cycle is still presenting the popped head.
    always_comb begin
        eligible = '0;
        starving = '0;
        dst_i    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dst_i       = req_dst[4*i +: 4];
            eligible[i] = req[i] & ~grant_q[i] & (|dst_i) & ~(|(dst_i & ~out_ready));
            starving[i] = (wait_cnt_q[i] == LIMIT);
        end
    end

    rr_pick u_pick (
        .eligible  (eligible),
        .starving  (starving),
        .dst       (req_dst),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_grant),
        .first_idx (first_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        grant_d     = pick_grant;
        rr_ptr_d    = any_grant ? first_idx + 2'd1 : rr_ptr_q;
        sel_valid_d = '0;
        sel_idx_d   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < 4; o++) begin
                if (pick_grant[i] && req_dst[4*i+o]) begin
                    sel_valid_d[o]       = 1'b1;
                    sel_idx_d[2*o +: 2]  = 2'(i);
                end
            end
            if (!req[i] || pick_grant[i]) begin
                wait_cnt_d[i] = '0;
            end else if (wait_cnt_q[i] == LIMIT) begin
                wait_cnt_d[i] = wait_cnt_q[i];
            end else begin
                wait_cnt_d[i] = wait_cnt_q[i] + 4'd1;
            end
        end
        // Transmit stage: selects hold when an output is idle.
        out_valid_d = sel_valid_q;
        out_sel_d   = out_sel_q;
        for (int o = 0; o < 4; o++) begin
            if (sel_valid_q[o]) begin
                out_sel_d[2*o +: 2] = sel_idx_q[2*o +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            sel_valid_q <= '0;
            sel_idx_q   <= '0;
            out_valid_q <= '0;
            out_sel_q   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_valid_q <= sel_valid_d;
            sel_idx_q   <= sel_idx_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign grant     = grant_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

`ifdef ARB_STATS_EN
    logic [63:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                grant_cnt_d[16*i +: 16] = grant_cnt_q[16*i +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_switch_arbiter.sv
// Scoreboard bench for switch_arbiter: a list-based reference model queues
// expected grants and outputs; a negedge monitor pops and compares them.
module tb_switch_arbiter;

    localparam int SL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_dst;
    logic [3:0]  out_ready;
    logic [3:0]  grant;
    logic [3:0]  out_valid;
    logic [7:0]  out_sel;
`ifdef ARB_STATS_EN
    logic [63:0] grant_cnt;
`endif

    switch_arbiter #(.NUM_PORTS(4), .STARVE_LIMIT(SL)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_dst   (req_dst),
        .out_ready (out_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .out_sel   (out_sel)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [3:0] g; } gexp_t;
    typedef struct { int c; logic [3:0] v; logic [7:0] s; } oexp_t;
    gexp_t gq[$];
    oexp_t oq[$];
    gexp_t ge;
    oexp_t oe;

    int         m_rr;
    int         m_wait [4];
    int         m_cnt  [4];
    logic [3:0] m_prev;
    logic [7:0] m_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_rr   = 0;
        m_prev = '0;
        m_sel  = '0;
        for (int p = 0; p < 4; p++) begin
            m_wait[p] = 0;
            m_cnt[p]  = 0;
        end
        gq.delete();
        oq.delete();
    endtask

    // Build the scan list (starving first, each group in rotation), then claim outputs.
    task automatic model_step();
        logic [3:0] g, claimed, d, v;
        int first, p;
        int order[$];
        g = '0; claimed = '0; v = '0; first = -1;
        for (int pass = 0; pass < 2; pass++)
            for (int k = 0; k < 4; k++) begin
                p = (m_rr + k) % 4;
                if ((m_wait[p] == SL) == (pass == 0)) order.push_back(p);
            end
        foreach (order[j]) begin
            p = order[j];
            d = req_dst[4*p +: 4];
            if (req[p] && !m_prev[p] && d != 0 && (d & ~out_ready) == 0 && (d & claimed) == 0) begin
                g[p] = 1'b1;
                claimed = claimed | d;
                v = v | d;
                if (first < 0) first = p;
                for (int o = 0; o < 4; o++)
                    if (d[o]) m_sel[2*o +: 2] = 2'(p);
            end
        end
        for (int q = 0; q < 4; q++) begin
            if (!req[q] || g[q]) m_wait[q] = 0;
            else if (m_wait[q] < SL) m_wait[q]++;
            if (g[q]) m_cnt[q]++;
        end
        if (first >= 0) m_rr = (first + 1) % 4;
        m_prev = g;
        if (g != 0) begin
            gq.push_back('{cyc + 1, g});
            oq.push_back('{cyc + 2, v, m_sel});
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (grant !== 4'b0) begin
                if (gq.size() == 0) check("grant_unexpected", grant, 0);
                else begin
                    ge = gq.pop_front();
                    check("grant", grant, ge.g);
                    check("grant_cycle", cyc, ge.c);
                end
            end else if (gq.size() > 0 && gq[0].c <= cyc) begin
                ge = gq.pop_front();
                check("grant_missing", grant, ge.g);
            end
            if (out_valid !== 4'b0) begin
                if (oq.size() == 0) check("out_unexpected", out_valid, 0);
                else begin
                    oe = oq.pop_front();
                    check("out_valid", out_valid, oe.v);
                    check("out_sel", out_sel, oe.s);
                    check("out_cycle", cyc, oe.c);
                end
            end else if (oq.size() > 0 && oq[0].c <= cyc) begin
                oe = oq.pop_front();
                check("out_missing", out_valid, oe.v);
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic [15:0] d, input logic [3:0] rd);
        req = r; req_dst = d; out_ready = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    logic [3:0]  r_r, r_rd, nd;
    logic [15:0] r_d;
    int          hit;

    initial begin
        rst = 1'b1;
        drive(4'b0, 16'h0, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sel", out_sel, 0);
        #2 rst = 1'b0;

        // unicast port1 -> output2
        tick(); drive(4'b0010, 16'h0040, 4'hF);
        tick(); check("t1_grant", grant, 4'b0010);
        drive(4'b0, 16'h0, 4'hF);
        tick(); check("t1_out_valid", out_valid, 4'b0100);
        check("t1_out_sel", out_sel[5:4], 2'b01);

        // two ports contending for output0 alternate
        pulse_reset();
        tick(); drive(4'b1001, 16'h1001, 4'hF);
        tick(); check("t2_grant_a", grant, 4'b0001);
        tick(); check("t2_grant_b", grant, 4'b1000);
        tick(); check("t2_grant_c", grant, 4'b0001);
        drive(4'b0, 16'h0, 4'hF);

        // disjoint grants in one cycle
        pulse_reset();
        tick(); drive(4'b0011, 16'h0021, 4'hF);
        tick(); check("t3_grant", grant, 4'b0011);
        drive(4'b0, 16'h0, 4'hF);
        tick(); check("t3_out_valid", out_valid, 4'b0011);
        check("t3_out_sel", out_sel[3:0], 4'b0100);

        // backpressure on output3
        tick(); drive(4'b0100, 16'h0800, 4'b0111);
        repeat (3) begin
            tick(); check("t4_blocked", grant, 0);
        end
        drive(4'b0100, 16'h0800, 4'hF);
        tick(); check("t4_grant", grant, 4'b0100);
        drive(4'b0, 16'h0, 4'hF);
        tick(); tick();

        // broadcast from port2 against unicast traffic on outputs 0 and 1
        drive(4'b0111, 16'h0F21, 4'hF);
        hit = 0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (grant[2]) begin
                hit = n;
                break;
            end
        end
        check("t5_starve_bound", 32'(hit >= 1 && hit <= 4), 1);
        drive(4'b0, 16'h0, 4'hF);
        tick();
        check("t5_out_valid", out_valid, 4'b1111);
        check("t5_out_sel", out_sel, 8'hAA);

        // asynchronous reset while a grant is showing
        pulse_reset();
        tick(); drive(4'b0001, 16'h0001, 4'hF);
        tick(); check("t6_pre_grant", grant, 4'b0001);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_grant", grant, 0);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_rr_ptr", dut.rr_ptr_q, 0);
        #2 rst = 1'b0;
        drive(4'b1001, 16'h1001, 4'hF);
        tick(); check("t6_first_grant", grant, 4'b0001);
        drive(4'b0, 16'h0, 4'hF);
        tick(); tick();

        // randomized traffic; a granted port loads a new head
        for (int c = 0; c < 400; c++) begin
            tick();
            r_r = req;
            r_d = req_dst;
            for (int p = 0; p < 4; p++) begin
                if (grant[p] || $urandom_range(0, 9) == 0) begin
                    r_r[p] = ($urandom_range(0, 9) < 7);
                    nd = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3))
                                                      : 4'($urandom_range(0, 15));
                    r_d[4*p +: 4] = nd;
                end
            end
            r_rd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            drive(r_r, r_d, r_rd);
        end
        drive(4'b0, 16'h0, 4'hF);
        repeat (5) tick();
        check("grant_queue_drained", gq.size(), 0);
        check("out_queue_drained", oq.size(), 0);
`ifdef ARB_STATS_EN
        for (int p = 0; p < 4; p++)
            check("grant_cnt", grant_cnt[16*p +: 16], 16'(m_cnt[p]));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
